// File: rtl/add_pipe.sv
// Pipelined ripple-carry adder, STAGES segments of SEG bits, valid/ready stream.
// Define ADD_PIPE_SAT_EN for the ovf port and signed saturation of sum.
module add_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADD_PIPE_SAT_EN
   ,
   output logic             ovf
`endif
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic              adv;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] c_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];

   logic [WIDTH-1:0]  ia  [STAGES];
   logic [WIDTH-1:0]  ib  [STAGES];
   logic [WIDTH-1:0]  is  [STAGES];
   logic [STAGES-1:0] ic;
   logic [WIDTH-1:0]  ns  [STAGES];
   logic [STAGES-1:0] nc;

   assign adv      = !vld_q[LAST] || out_ready;
   assign in_ready = adv;

   // each stage reads only registered operands, so no carry crosses a boundary
   always_comb begin
      ia[0] = a;
      ib[0] = b;
      is[0] = '0;
      ic[0] = cin;
      for (int k = 1; k < STAGES; k++) begin
         ia[k] = a_q[k-1];
         ib[k] = b_q[k-1];
         is[k] = s_q[k-1];
         ic[k] = c_q[k-1];
      end
   end

   always_comb begin
      logic [SEG:0] part;
      part = '0;
      for (int k = 0; k < STAGES; k++) begin
         part = {1'b0, ia[k][k*SEG +: SEG]}
              + {1'b0, ib[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, ic[k]};
         ns[k] = is[k];
         ns[k][k*SEG +: SEG] = part[SEG-1:0];
         nc[k] = part[SEG];
      end
   end

`ifdef ADD_PIPE_SAT_EN
   logic             ovf_n;
   logic             ovf_q;
   logic [WIDTH-1:0] fin_s;

   always_comb begin
      ovf_n = (ia[LAST][WIDTH-1] == ib[LAST][WIDTH-1])
           && (ns[LAST][WIDTH-1] != ia[LAST][WIDTH-1]);
      fin_s = ns[LAST];
      if (ovf_n)
         fin_s = ia[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (adv)
         ovf_q <= ovf_n;
   end

   assign ovf = ovf_q;
`else
   logic [WIDTH-1:0] fin_s;

   assign fin_s = ns[LAST];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         c_q   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (adv) begin
         vld_q[0] <= in_valid;
         for (int k = 1; k < STAGES; k++)
            vld_q[k] <= vld_q[k-1];
         c_q <= nc;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= ia[k];
            b_q[k] <= ib[k];
            s_q[k] <= (k == LAST) ? fin_s : ns[k];
         end
      end
   end

   assign out_valid = vld_q[LAST];
   assign sum       = s_q[LAST];
   assign cout      = c_q[LAST];

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe (WIDTH=16, STAGES=4) with a queue scoreboard.
// Covers reset, carries, streaming, backpressure, async reset and saturation.
module tb_add_pipe;

   localparam int W = 16;
   localparam int S = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf_w;

   add_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef ADD_PIPE_SAT_EN
      ,
      .ovf       (ovf_w)
`endif
   );

`ifndef ADD_PIPE_SAT_EN
   assign ovf_w = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W+1:0] r;
      int           c;
   } ent_t;

   ent_t         q[$];
   int           rq[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           n_acc = 0;
   bit           lat_en = 0;
   bit           hold_prev = 0;
   logic [W+1:0] prev;
   logic [W-1:0] last_sum;
   logic         last_cout;
   logic         last_ovf;

   // {ovf, cout, sum} straight from the arithmetic definition
   function automatic logic [W+1:0] ref_add(logic [W-1:0] x, logic [W-1:0] y,
                                            logic c);
      logic [W:0]   full;
      logic [W-1:0] s;
      logic         o;
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      s    = full[W-1:0];
      o    = 1'b0;
`ifdef ADD_PIPE_SAT_EN
      o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      if (o) s = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
      return {o, full[W], s};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      ent_t e;
      @(negedge clk);
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
      if (hold_prev) begin
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_data", {14'd0, ovf_w, cout, sum}, {14'd0, prev});
      end
      if (out_valid && out_ready) begin
         n_cmp++;
         assert (q.size() > 0) else begin
            n_err++;
            $error("FAIL spurious: got beat %h want none", sum);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("result", {14'd0, ovf_w, cout, sum}, {14'd0, e.r});
            if (lat_en) chk("latency", cyc - e.c, S);
         end
         rq.push_back(cyc);
         last_sum  = sum;
         last_cout = cout;
         last_ovf  = ovf_w;
      end
      if (in_valid && in_ready) begin
         q.push_back('{ref_add(a, b, cin), cyc});
         n_acc++;
      end
      hold_prev = out_valid && !out_ready;
      prev      = {ovf_w, cout, sum};
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(int budget);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (q.size() > 0 && budget > 0) begin
         cycle();
         budget--;
      end
      n_cmp++;
      assert (q.size() == 0) else begin
         n_err++;
         $error("FAIL drain: got %0d pending want 0", q.size());
      end
   endtask

   task automatic push1(logic [W-1:0] x, logic [W-1:0] y, logic c);
      a        = x;
      b        = y;
      cin      = c;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      drain(20);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'b1;

      repeat (3) begin
         @(negedge clk);
         chk("rst_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_sum", {16'd0, sum}, 32'd0);
         chk("rst_cout", {31'd0, cout}, 32'd0);
         chk("rst_ovf", {31'd0, ovf_w}, 32'd0);
         chk("rst_ready", {31'd0, in_ready}, 32'd1);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b1;

      lat_en = 1;
      push1(16'h00FF, 16'h0001, 1'b0);
      chk("xseg_sum", {16'd0, last_sum}, 32'h0100);
      chk("xseg_cout", {31'd0, last_cout}, 32'd0);
      push1(16'hFFFF, 16'h0000, 1'b1);
      chk("wrap_sum", {16'd0, last_sum}, 32'h0000);
      chk("wrap_cout", {31'd0, last_cout}, 32'd1);

      rq.delete();
      for (int i = 0; i < 8; i++) begin
         a        = W'(i * 16'h1111);
         b        = 16'h0F0F;
         cin      = 1'(i & 1);
         in_valid = 1'b1;
         chk("stream_ready", {31'd0, in_ready}, 32'd1);
         cycle();
      end
      drain(20);
      chk("stream_count", rq.size(), 8);
      if (rq.size() == 8) chk("stream_gap", rq[7] - rq[0], 7);

      lat_en = 0;
      for (int i = 0; i < 4; i++) begin
         a        = W'($urandom);
         b        = W'($urandom);
         cin      = 1'($urandom);
         in_valid = 1'b1;
         cycle();
      end
      for (int j = 0; j < 3; j++) begin
         a         = W'($urandom);
         out_ready = 1'b0;
         #1;
         chk("bp_ready", {31'd0, in_ready}, 32'd0);
         cycle();
      end
      drain(20);

      begin
         int budget;
         budget = 3000;
         n_acc  = 0;
         while (n_acc < 200 && budget > 0) begin
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            cycle();
            budget--;
         end
         chk("rand_accepted", n_acc, 200);
      end
      drain(40);

      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         a        = W'($urandom);
         b        = W'($urandom);
         cin      = 1'($urandom);
         in_valid = 1'b1;
         cycle();
      end
      in_valid = 1'b0;
      chk("midrst_pre", {31'd0, out_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_sum", {16'd0, sum}, 32'd0);
      q.delete();
      hold_prev = 0;
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      a         = 'x;
      b         = 'x;
      cin       = 1'bx;
      repeat (10) begin
         cycle();
         chk("x_valid", {31'd0, out_valid}, 32'd0);
      end

      lat_en = 1;
      push1(16'h7FFF, 16'h0001, 1'b0);
`ifdef ADD_PIPE_SAT_EN
      chk("sat_max_sum", {16'd0, last_sum}, 32'h7FFF);
      chk("sat_max_ovf", {31'd0, last_ovf}, 32'd1);
`else
      chk("wrap_max_sum", {16'd0, last_sum}, 32'h8000);
`endif
      push1(16'h8000, 16'hFFFF, 1'b0);
`ifdef ADD_PIPE_SAT_EN
      chk("sat_min_sum", {16'd0, last_sum}, 32'h8000);
      chk("sat_min_ovf", {31'd0, last_ovf}, 32'd1);
`else
      chk("wrap_min_sum", {16'd0, last_sum}, 32'h7FFF);
`endif
      chk("sat_min_cout", {31'd0, last_cout}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
